// File: rtl/vdma_pkg.sv
// Shared VDMA definitions: FSM encodings, default sizes, edge detector modes.
// No logic; constants only.
// No flow control.
package vdma_pkg;

  // Controller state encoding shared with the read-side status controller
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    NEED_WR   = 4'd1,
    WAIT_DONE = 4'd2,
    FSH       = 4'd3,
    WR_TAIL   = 4'd4
  } vdma_state_e;

  // Edge detector flavours; NORMAL is the rising edge
  typedef enum logic [1:0] {
    EDGE_NORMAL = 2'd0,
    EDGE_FALL   = 2'd1,
    EDGE_BOTH   = 2'd2
  } edge_mode_e;

  localparam int VDMA_THRESHOLD = 128;
  localparam int VDMA_LSIZE     = 9;

endpackage

// File: rtl/write_fifo_status_ctrl_if.sv
// Request/response channel between the FIFO status controller and the burst master.
// Pure wiring, zero latency.
// Requests are levels held until resp; resp/done are single-cycle pulses.
interface write_fifo_status_ctrl_if #(
  parameter int LSIZE = 9
);
  logic             burst_req;
  logic             tail_req;
  logic [LSIZE-1:0] req_len;
  logic             resp;
  logic             done;

  // Controller side: raises requests, receives acknowledgements
  modport master (
    output burst_req, tail_req, req_len,
    input  resp, done
  );

  // Burst master side
  modport slave (
    input  burst_req, tail_req, req_len,
    output resp, done
  );
endinterface

// File: rtl/edge_generator.sv
// Single-cycle pulse on a selected edge of a level input.
// Pulse is combinational against a one-cycle registered copy of the input.
// No flow control; one pulse per qualifying transition.
module edge_generator
  import vdma_pkg::*;
#(
  parameter edge_mode_e MODE = EDGE_NORMAL
) (
  input  logic clock,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  // Previous-cycle copy of the input
  always_ff @(posedge clock) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  // Compare current level against the previous one for the selected edge
  always_comb begin
    pulse = 1'b0;
    case (MODE)
      EDGE_NORMAL: pulse = sig & ~sig_q;
      EDGE_FALL:   pulse = ~sig & sig_q;
      EDGE_BOTH:   pulse = sig ^ sig_q;
      default:     pulse = 1'b0;
    endcase
  end

endmodule

// File: rtl/write_fifo_status_ctrl.sv
// Ingress FIFO status controller: requests full bursts at THRESHOLD, one tail burst per frame.
// count>=THRESHOLD to burst_req is 2 cycles; all outputs registered from next state.
// Requests held until resp; next request waits for done, FSH and one IDLE cycle.
module write_fifo_status_ctrl
  import vdma_pkg::*;
#(
  parameter int THRESHOLD = VDMA_THRESHOLD,
  parameter int FULL_LEN  = 256,
  parameter int CSIZE     = 9,
  parameter int LSIZE     = VDMA_LSIZE
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [CSIZE-1:0]       count,
  input  logic                   tail_status,
  input  logic [LSIZE-1:0]       tail_len,
  write_fifo_status_ctrl_if.master wr,
  output logic                   frame_done,
  output logic                   busy
);

  if (THRESHOLD > FULL_LEN) begin : g_thr_vs_depth
    $error("THRESHOLD must not exceed FULL_LEN");
  end
  if (THRESHOLD >= (1 << CSIZE) || THRESHOLD >= (1 << LSIZE)) begin : g_thr_width
    $error("THRESHOLD does not fit in CSIZE/LSIZE");
  end

  localparam int CW = (CSIZE > LSIZE) ? CSIZE : LSIZE;
  localparam logic [CSIZE-1:0] THR_CNT = CSIZE'(THRESHOLD);
  localparam logic [LSIZE-1:0] THR_LEN = LSIZE'(THRESHOLD);

  vdma_state_e      state, nstate;
  logic             trigger_req;
  logic             tail_rise;
  logic             tail_pending;
  logic             tail_flag, nxt_tail_flag;
  logic             tail_skip;
  logic             tail_fits;
  logic             burst_req_q, tail_req_q;
  logic [LSIZE-1:0] req_len_q;

  assign wr.burst_req = burst_req_q;
  assign wr.tail_req  = tail_req_q;
  assign wr.req_len   = req_len_q;

  // Residue is all in the FIFO once count covers tail_len
  assign tail_fits = (CW'(count) >= CW'(tail_len));

  edge_generator #(.MODE(EDGE_NORMAL)) u_tail_edge (
    .clock (clock),
    .rst   (rst),
    .sig   (tail_status),
    .pulse (tail_rise)
  );

  // Registered full-burst trigger; enable gates it at the source
  always_ff @(posedge clock) begin
    if (rst) trigger_req <= 1'b0;
    else     trigger_req <= enable && (count >= THR_CNT);
  end

  // One pending tail per rising edge of tail_status; a new rise wins over a same-cycle clear
  always_ff @(posedge clock) begin
    if (rst)                                        tail_pending <= 1'b0;
    else if (tail_rise)                             tail_pending <= 1'b1;
    else if ((state == WR_TAIL && wr.resp) || tail_skip) tail_pending <= 1'b0;
  end

  // Next-state decode; full bursts drain before the tail is considered
  always_comb begin
    nstate        = state;
    nxt_tail_flag = tail_flag;
    tail_skip     = 1'b0;
    case (state)
      IDLE: begin
        if (trigger_req) begin
          nstate        = NEED_WR;
          nxt_tail_flag = 1'b0;
        end else if (enable && tail_pending && tail_len != '0 && tail_fits) begin
          nstate        = WR_TAIL;
          nxt_tail_flag = 1'b1;
        end else if (enable && tail_pending && tail_len == '0) begin
          nstate        = FSH;
          nxt_tail_flag = 1'b1;
          tail_skip     = 1'b1;
        end
      end
      NEED_WR, WR_TAIL: begin
        if (wr.resp && wr.done) nstate = FSH;
        else if (wr.resp)       nstate = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wr.done) nstate = FSH;
      end
      FSH: begin
        nstate        = IDLE;
        nxt_tail_flag = 1'b0;
      end
      default: begin
        nstate        = IDLE;
        nxt_tail_flag = 1'b0;
      end
    endcase
  end

  // State and registered outputs, all decoded from the next state
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      tail_flag   <= 1'b0;
      burst_req_q <= 1'b0;
      tail_req_q  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      req_len_q   <= '0;
    end else begin
      state       <= nstate;
      tail_flag   <= nxt_tail_flag;
      burst_req_q <= (nstate == NEED_WR);
      tail_req_q  <= (nstate == WR_TAIL);
      busy        <= (nstate != IDLE);
      frame_done  <= (nstate == FSH) && nxt_tail_flag;
      if (state == IDLE && nstate == NEED_WR)      req_len_q <= THR_LEN;
      else if (state == IDLE && nstate == WR_TAIL) req_len_q <= tail_len;
    end
  end

endmodule

// File: tb/tb_write_fifo_status_ctrl.sv
module tb_write_fifo_status_ctrl;
  import vdma_pkg::*;

  localparam int CSIZE = 9;
  localparam int LSIZE = 9;

  logic             clock = 1'b0;
  logic             rst;
  logic             enable;
  logic [CSIZE-1:0] count;
  logic             tail_status;
  logic [LSIZE-1:0] tail_len;
  logic             frame_done;
  logic             busy;

  write_fifo_status_ctrl_if #(.LSIZE(LSIZE)) wr ();

  write_fifo_status_ctrl #(
    .THRESHOLD (128),
    .FULL_LEN  (256),
    .CSIZE     (CSIZE),
    .LSIZE     (LSIZE)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .enable      (enable),
    .count       (count),
    .tail_status (tail_status),
    .tail_len    (tail_len),
    .wr          (wr.master),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             rst, en;
    logic [CSIZE-1:0] cnt;
    logic             ts;
    logic [LSIZE-1:0] tl;
    logic             resp, done;
    logic             br, tr, fd, bz;
    logic [LSIZE-1:0] len;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(int r, int e, int c, int t, int l, int rs, int d,
                              int br, int tr, int fd, int bz, int len);
    vec_t v;
    v.rst = (r != 0);   v.en = (e != 0);   v.cnt = CSIZE'(c);
    v.ts = (t != 0);    v.tl = LSIZE'(l);  v.resp = (rs != 0); v.done = (d != 0);
    v.br = (br != 0);   v.tr = (tr != 0);  v.fd = (fd != 0);   v.bz = (bz != 0);
    v.len = LSIZE'(len);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({wr.burst_req, wr.tail_req, frame_done, busy, wr.req_len});
  endfunction

  task automatic wait_burst(input string name, input int maxc);
    int n = 0;
    while (!wr.burst_req && n < maxc) begin step(); n++; end
    check(name, 32'(wr.burst_req), 32'd1);
  endtask

  task automatic wait_tail(input string name, input int maxc);
    int n = 0;
    while (!wr.tail_req && n < maxc) begin step(); n++; end
    check(name, 32'(wr.tail_req), 32'd1);
  endtask

  initial begin
    logic [2:0] gap;
    logic       ok;

    rst = 1'b1; enable = 1'b0; count = '0; tail_status = 1'b0; tail_len = '0;
    wr.resp = 1'b0; wr.done = 1'b0;

    //            rst en cnt ts tl rsp dn | br tr fd bz len
    vecs[0]  = mk(1, 0,   0, 0,  0, 0, 0,   0, 0, 0, 0,   0);
    vecs[1]  = mk(0, 1, 100, 0,  0, 0, 0,   0, 0, 0, 0,   0);
    vecs[2]  = mk(0, 1, 128, 0,  0, 0, 0,   0, 0, 0, 0,   0);
    vecs[3]  = mk(0, 1, 128, 0,  0, 0, 0,   1, 0, 0, 1, 128);
    vecs[4]  = mk(0, 1, 128, 0,  0, 0, 0,   1, 0, 0, 1, 128);
    vecs[5]  = mk(0, 1, 128, 0,  0, 0, 0,   1, 0, 0, 1, 128);
    vecs[6]  = mk(0, 1,   0, 0,  0, 1, 0,   0, 0, 0, 1, 128);
    vecs[7]  = mk(0, 1,   0, 0,  0, 0, 0,   0, 0, 0, 1, 128);
    vecs[8]  = mk(0, 1,   0, 0,  0, 0, 1,   0, 0, 0, 1, 128);
    vecs[9]  = mk(0, 1,   0, 0,  0, 0, 0,   0, 0, 0, 0, 128);
    // zero-length tail: skipped, frame_done two edges after the rise
    vecs[10] = mk(0, 1,   0, 1,  0, 0, 0,   0, 0, 0, 0, 128);
    vecs[11] = mk(0, 1,   0, 1,  0, 0, 0,   0, 0, 1, 1, 128);
    vecs[12] = mk(0, 1,   0, 1,  0, 0, 0,   0, 0, 0, 0, 128);
    vecs[13] = mk(0, 1,   0, 1,  0, 0, 0,   0, 0, 0, 0, 128);
    // 37-word tail
    vecs[14] = mk(0, 1,   0, 0,  0, 0, 0,   0, 0, 0, 0, 128);
    vecs[15] = mk(0, 1,  37, 1, 37, 0, 0,   0, 0, 0, 0, 128);
    vecs[16] = mk(0, 1,  37, 1, 37, 0, 0,   0, 1, 0, 1,  37);
    vecs[17] = mk(0, 1,  37, 1, 37, 1, 0,   0, 0, 0, 1,  37);
    vecs[18] = mk(0, 1,  37, 1, 37, 0, 1,   0, 0, 1, 1,  37);
    vecs[19] = mk(0, 1,  37, 1, 37, 0, 0,   0, 0, 0, 0,  37);
    vecs[20] = mk(0, 1,  37, 1, 37, 0, 0,   0, 0, 0, 0,  37);
    // resp and done together in NEED_WR: straight to FSH, no frame_done
    vecs[21] = mk(0, 1, 200, 1, 37, 0, 0,   0, 0, 0, 0,  37);
    vecs[22] = mk(0, 1, 200, 1, 37, 0, 0,   1, 0, 0, 1, 128);
    vecs[23] = mk(0, 1,   0, 1, 37, 1, 1,   0, 0, 0, 1, 128);
    vecs[24] = mk(0, 1,   0, 1, 37, 0, 0,   0, 0, 0, 0, 128);
    // enable low with count above threshold: nothing issued
    vecs[25] = mk(0, 0, 200, 1, 37, 0, 0,   0, 0, 0, 0, 128);
    vecs[26] = mk(0, 0, 200, 1, 37, 0, 0,   0, 0, 0, 0, 128);
    vecs[27] = mk(0, 0, 200, 1, 37, 0, 0,   0, 0, 0, 0, 128);
    // reset while in WAIT_DONE
    vecs[28] = mk(0, 1, 200, 0, 37, 0, 0,   0, 0, 0, 0, 128);
    vecs[29] = mk(0, 1, 200, 0, 37, 0, 0,   1, 0, 0, 1, 128);
    vecs[30] = mk(0, 1,   0, 0, 37, 1, 0,   0, 0, 0, 1, 128);
    vecs[31] = mk(1, 1,   0, 0, 37, 0, 0,   0, 0, 0, 0,   0);
    vecs[32] = mk(0, 1,   0, 0, 37, 0, 0,   0, 0, 0, 0,   0);

    #1;
    for (int i = 0; i < 33; i++) begin
      rst = vecs[i].rst; enable = vecs[i].en; count = vecs[i].cnt;
      tail_status = vecs[i].ts; tail_len = vecs[i].tl;
      wr.resp = vecs[i].resp; wr.done = vecs[i].done;
      step();
      check($sformatf("vec[%0d] {br,tr,fd,busy,len}", i), outs(),
            32'({vecs[i].br, vecs[i].tr, vecs[i].fd, vecs[i].bz, vecs[i].len}));
    end
    wr.resp = 1'b0; wr.done = 1'b0;

    // Ramp 0..128: burst_req rises on the second edge that sees 128
    rst = 1'b1; step(); rst = 1'b0; enable = 1'b1; tail_status = 1'b0;
    for (int c = 0; c < 128; c++) begin count = CSIZE'(c); step(); end
    count = CSIZE'(128); step();
    check("ramp_no_early_req", 32'(wr.burst_req), 32'd0);
    step();
    check("ramp_burst_latency", 32'({wr.burst_req, busy}), 32'b11);
    check("ramp_req_len", 32'(wr.req_len), 32'd128);
    step(); step();
    wr.resp = 1'b1; count = '0; step(); wr.resp = 1'b0;
    check("ramp_req_drop_after_resp", 32'({wr.burst_req, busy}), 32'b01);
    ok = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      if (!busy || wr.burst_req || wr.req_len != LSIZE'(128)) ok = 1'b0;
    end
    check("ramp_busy_through_burst", 32'(ok), 32'd1);
    wr.done = 1'b1; step(); wr.done = 1'b0;
    check("ramp_fsh_busy_no_fd", 32'({busy, frame_done}), 32'b10);
    step();
    check("ramp_idle_after_fsh", 32'(busy), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); if (wr.burst_req || busy) ok = 1'b0; end
    check("ramp_single_burst", 32'(ok), 32'd1);

    // Saturated count: bursts back to back, done cycle + FSH + IDLE between them
    count = CSIZE'(300);
    wait_burst("sat_first_burst", 10);
    for (int k = 0; k < 3; k++) begin
      wr.resp = 1'b1; step(); wr.resp = 1'b0;
      wr.done = 1'b1; step(); wr.done = 1'b0;
      gap[2] = wr.burst_req; step();
      gap[1] = wr.burst_req; step();
      gap[0] = wr.burst_req;
      check($sformatf("sat_gap[%0d]", k), 32'(gap), 32'b001);
    end
    count = '0; wr.resp = 1'b1; wr.done = 1'b1; step();
    wr.resp = 1'b0; wr.done = 1'b0; step(); step();
    check("sat_drained_idle", 32'({busy, frame_done}), 32'b00);

    // Tail rises during a full burst: full burst first, then the tail
    tail_len = LSIZE'(42); count = CSIZE'(170);
    wait_burst("mix_full_burst", 10);
    tail_status = 1'b1; step(); step();
    wr.resp = 1'b1; count = CSIZE'(42); step(); wr.resp = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); if (wr.tail_req || frame_done) ok = 1'b0; end
    check("mix_no_tail_during_full", 32'(ok), 32'd1);
    wr.done = 1'b1; step(); wr.done = 1'b0;
    check("mix_no_fd_after_full", 32'(frame_done), 32'd0);
    wait_tail("mix_tail_req", 6);
    check("mix_tail_len", 32'(wr.req_len), 32'd42);
    wr.resp = 1'b1; step(); wr.resp = 1'b0;
    wr.done = 1'b1; step(); wr.done = 1'b0;
    check("mix_fd_after_tail", 32'(frame_done), 32'd1);
    step();
    check("mix_fd_one_cycle", 32'({frame_done, busy}), 32'b00);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); if (wr.tail_req || frame_done) ok = 1'b0; end
    check("mix_no_second_tail", 32'(ok), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
